// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the byte-serial load/store initiator:
//   - access size encodings (byte / half / word / double)
//   - FSM state enumeration
//   - size_bytes(): number of byte beats for a given access size
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    // Byte count N = 1 << size (1, 2, 4 or 8).
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// -----------------------------------------------------------------------------
// lsu_load_extend
// Purely combinational load-result formatter. Takes the little-endian byte
// buffer collected during a load and returns the low 8*N bits sign- or
// zero-extended to 64 bits.
//
// Ports:
//   buf_i       in  64  assembled load bytes (byte k at bits 8k+7:8k)
//   size_i      in   2  access size (SZ_B/SZ_H/SZ_W/SZ_D)
//   unsigned_i  in   1  1 = zero-extend, 0 = sign-extend (ignored for SZ_D)
//   result_o    out 64  extended load value
// -----------------------------------------------------------------------------
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [63:0] buf_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [63:0] result_o
);

    logic sign_b;
    logic sign_h;
    logic sign_w;

    // Fill bit is the top bit of the accessed field, forced to 0 for unsigned loads.
    assign sign_b = buf_i[7]  & ~unsigned_i;
    assign sign_h = buf_i[15] & ~unsigned_i;
    assign sign_w = buf_i[31] & ~unsigned_i;

    always_comb begin
        result_o = '0;
        case (size_i)
            SZ_B:    result_o = {{56{sign_b}}, buf_i[7:0]};
            SZ_H:    result_o = {{48{sign_h}}, buf_i[15:0]};
            SZ_W:    result_o = {{32{sign_w}}, buf_i[31:0]};
            default: result_o = buf_i;
        endcase
    end

endmodule

// File: rtl/lsu_byte_master.sv
// -----------------------------------------------------------------------------
// lsu_byte_master
// Load/store initiator between the MEM stage and a byte-wide data memory port.
// Accepts one request at a time in IDLE, serialises it into little-endian byte
// beats (one per mem_req && mem_ready), then issues a one-cycle response.
// Misaligned requests skip the memory and respond immediately with a flag.
// All outputs are registered.
//
// Ports:
//   clk, reset_n           clock / asynchronous active-low reset
//   req_valid, req_ready   request handshake (ready only in IDLE)
//   req_write              1 = store, 0 = load
//   req_size               00 B, 01 H, 10 W, 11 D
//   req_unsigned           loads: 1 = zero-extend, 0 = sign-extend
//   req_addr, req_wdata    byte address / store data (low 8*N bits used)
//   resp_valid             one-cycle completion strobe
//   resp_rdata             extended load data (0 for stores / misaligned)
//   resp_misaligned        address not aligned to the access size
//   busy                   high whenever not IDLE
//   mem_req, mem_we        beat request / beat is a write
//   mem_addr, mem_wdata    beat byte address / write byte
//   mem_rdata, mem_ready   read byte / beat completes this cycle
// -----------------------------------------------------------------------------
module lsu_byte_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int XLEN   = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_misaligned,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready
);

    lsu_state_e        state_q, state_d;
    logic [2:0]        k_q, k_d;
    logic [1:0]        size_q, size_d;
    logic              write_q, write_d;
    logic              uns_q, uns_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   buf_q, buf_d;

    logic              req_ready_q, req_ready_d;
    logic              busy_q, busy_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
    logic              resp_mis_q, resp_mis_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;

    logic [3:0]        n_req;
    logic [3:0]        n_cur;
    logic [2:0]        align_mask;
    logic              req_misaligned;
    logic              last_beat;
    logic [2:0]        k_nxt;
    logic [XLEN-1:0]   buf_merged;
    logic [63:0]       ext_result;

    // Alignment check: any set address bit below log2(N) means misaligned.
    // For SZ_D, n_req[2:0] is 0, so the mask wraps to 3'b111 as intended.
    assign n_req          = size_bytes(req_size);
    assign align_mask     = n_req[2:0] - 3'd1;
    assign req_misaligned = |(req_addr[2:0] & align_mask);

    assign n_cur     = size_bytes(size_q);
    assign last_beat = ({1'b0, k_q} == (n_cur - 4'd1));
    assign k_nxt     = k_q + 3'd1;

    // Buffer with the current beat's read byte merged in, so the final beat's
    // byte is already visible to the extender on the completing edge.
    always_comb begin
        buf_merged = buf_q;
        buf_merged[{k_q, 3'b000} +: 8] = mem_rdata;
    end

    lsu_load_extend u_load_extend (
        .buf_i      (buf_merged),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .result_o   (ext_result)
    );

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        size_d       = size_q;
        write_d      = write_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
        buf_d        = buf_q;
        req_ready_d  = req_ready_q;
        busy_d       = busy_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_mis_d   = resp_mis_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    size_d      = req_size;
                    write_d     = req_write;
                    uns_d       = req_unsigned;
                    wdata_d     = req_wdata;
                    buf_d       = '0;
                    k_d         = 3'd0;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    if (req_misaligned) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_mis_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        // Beat 0 is presented on the cycle after acceptance.
                        state_d     = ST_XFER;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_write;
                        mem_addr_d  = req_addr;
                        mem_wdata_d = req_wdata[7:0];
                    end
                end
            end

            ST_XFER: begin
                // Without mem_ready every mem_* register simply holds.
                if (mem_ready) begin
                    if (!write_q) begin
                        buf_d = buf_merged;
                    end
                    if (last_beat) begin
                        state_d      = ST_RESP;
                        mem_req_d    = 1'b0;
                        mem_we_d     = 1'b0;
                        mem_addr_d   = '0;
                        mem_wdata_d  = '0;
                        resp_valid_d = 1'b1;
                        resp_mis_d   = 1'b0;
                        resp_rdata_d = write_q ? '0 : ext_result;
                    end else begin
                        k_d         = k_nxt;
                        mem_addr_d  = mem_addr_q + ADDR_W'(1);
                        mem_wdata_d = wdata_q[{k_nxt, 3'b000} +: 8];
                    end
                end
            end

            ST_RESP: begin
                state_d      = ST_IDLE;
                resp_rdata_d = '0;
                resp_mis_d   = 1'b0;
                req_ready_d  = 1'b1;
                busy_d       = 1'b0;
            end

            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
                mem_req_d   = 1'b0;
                mem_we_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            size_q       <= '0;
            write_q      <= 1'b0;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
            buf_q        <= '0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_mis_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            size_q       <= size_d;
            write_q      <= write_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
            buf_q        <= buf_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_mis_q   <= resp_mis_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign busy            = busy_q;
    assign resp_valid      = resp_valid_q;
    assign resp_rdata      = resp_rdata_q;
    assign resp_misaligned = resp_mis_q;
    assign mem_req         = mem_req_q;
    assign mem_we          = mem_we_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;

endmodule

// File: tb/tb_lsu_byte_master.sv
module tb_lsu_byte_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_misaligned;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready;

    int total = 0;
    int bad   = 0;

    // Byte memory model (addresses used by the bench are all below 512).
    logic [7:0]  mem [0:511];
    logic        pl_en;
    logic [8:0]  pl_addr;
    logic [7:0]  pl_data;

    logic [63:0] beat_q[$];
    logic [63:0] stall_q[$];
    int          memreq_cnt;

    always #5 clk = ~clk;

    lsu_byte_master #(.ADDR_W(64), .XLEN(64)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .busy            (busy),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_ready       (mem_ready)
    );

    assign mem_rdata = mem[mem_addr[8:0]];

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_addr] <= pl_data;
        else if (mem_req && mem_ready && mem_we)
            mem[mem_addr[8:0]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic poke(input int a, input logic [7:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = 9'(a);
        pl_data = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    function automatic logic [63:0] peek8(input int base);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = mem[base + i];
        return v;
    endfunction

    // Issue one request, serve beats (optionally stalling one beat), and
    // return the response and its latency in cycles after acceptance.
    task automatic run_req(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [63:0] addr, input logic [63:0] wd,
                           input int stall_beat, input int stall_n,
                           output logic [63:0] rd, output logic mis, output int lat);
        int beats;
        int left;
        bit done;
        beats = 0; left = stall_n; done = 1'b0; lat = -1; rd = '0; mis = 1'b0;
        beat_q.delete(); stall_q.delete(); memreq_cnt = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        for (int c = 1; c <= 60 && !done; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            mem_ready = 1'b1;
            if (resp_valid) begin
                lat = c; rd = resp_rdata; mis = resp_misaligned; done = 1'b1;
            end else if (mem_req) begin
                memreq_cnt++;
                if (beats == stall_beat && left > 0) begin
                    mem_ready = 1'b0;
                    left--;
                    stall_q.push_back(mem_addr);
                end else begin
                    beat_q.push_back(mem_addr);
                    beats++;
                end
            end
        end
        if (!done) chk("timeout", 64'd0, 64'd1);
        mem_ready = 1'b1;
    endtask

    initial begin
        logic [63:0] rd;
        logic        mis;
        int          lat;

        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; mem_ready = 1'b1;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_mis", resp_misaligned, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        @(posedge clk);
        #2 reset_n = 1'b1;

        // Memory image
        poke(256, 8'h04);
        for (int i = 257; i < 264; i++) poke(i, 8'h00);
        poke(300, 8'h80);
        poke(272, 8'hFE); poke(273, 8'hFF); poke(274, 8'h12); poke(275, 8'h84);
        for (int i = 280; i < 288; i++) poke(i, 8'hAA);

        // Doubleword load
        run_req(1'b0, 2'b11, 1'b0, 64'd256, 64'd0, -1, 0, rd, mis, lat);
        chk("ld256_data", rd, 64'd4);
        chk("ld256_mis", mis, 0);
        chk("ld256_lat", lat, 9);
        chk("ld256_nbeats", beat_q.size(), 8);
        for (int i = 0; i < beat_q.size(); i++) chk("ld256_addr", beat_q[i], 64'd256 + i);

        // Byte loads
        run_req(1'b0, 2'b00, 1'b0, 64'd300, 64'd0, -1, 0, rd, mis, lat);
        chk("lb300_data", rd, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb300_lat", lat, 2);
        chk("lb300_nbeats", beat_q.size(), 1);
        run_req(1'b0, 2'b00, 1'b1, 64'd300, 64'd0, -1, 0, rd, mis, lat);
        chk("lbu300_data", rd, 64'h0000_0000_0000_0080);

        // Store then load back
        run_req(1'b1, 2'b11, 1'b0, 64'd264, 64'h1122334455667788, -1, 0, rd, mis, lat);
        chk("sd264_rdata", rd, 64'd0);
        chk("sd264_lat", lat, 9);
        @(negedge clk);
        chk("sd264_mem", peek8(264), 64'h1122334455667788);
        run_req(1'b0, 2'b11, 1'b0, 64'd264, 64'd0, -1, 0, rd, mis, lat);
        chk("ld264_data", rd, 64'h1122334455667788);

        // Word load with two wait states on beat 2
        run_req(1'b0, 2'b10, 1'b0, 64'd272, 64'd0, 2, 2, rd, mis, lat);
        chk("lw272_data", rd, 64'hFFFF_FFFF_8412_FFFE);
        chk("lw272_lat", lat, 7);
        chk("lw272_nstall", stall_q.size(), 2);
        for (int i = 0; i < stall_q.size(); i++) chk("lw272_hold_addr", stall_q[i], 64'd274);
        run_req(1'b0, 2'b10, 1'b1, 64'd272, 64'd0, -1, 0, rd, mis, lat);
        chk("lwu272_data", rd, 64'h0000_0000_8412_FFFE);
        run_req(1'b0, 2'b01, 1'b0, 64'd272, 64'd0, -1, 0, rd, mis, lat);
        chk("lh272_data", rd, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("lh272_lat", lat, 3);
        run_req(1'b0, 2'b01, 1'b1, 64'd272, 64'd0, -1, 0, rd, mis, lat);
        chk("lhu272_data", rd, 64'h0000_0000_0000_FFFE);

        // Misaligned word load
        run_req(1'b0, 2'b10, 1'b0, 64'd258, 64'd0, -1, 0, rd, mis, lat);
        chk("mis_flag", mis, 1);
        chk("mis_rdata", rd, 64'd0);
        chk("mis_lat", lat, 1);
        chk("mis_memreq", memreq_cnt, 0);
        chk("mis_ready_T1", req_ready, 0);
        @(negedge clk);
        chk("mis_ready_T2", req_ready, 1);
        chk("mis_busy_T2", busy, 0);

        // Reset in the middle of a doubleword store
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b11; req_unsigned = 1'b0;
        req_addr = 64'd280; req_wdata = 64'h0102030405060708;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_mid_memreq", mem_req, 1);
        chk("rst_mid_busy", busy, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_mem_req", mem_req, 0);
        chk("rst_mid_mem_we", mem_we, 0);
        chk("rst_mid_mem_addr", mem_addr, 0);
        chk("rst_mid_mem_wdata", mem_wdata, 0);
        chk("rst_mid_busy0", busy, 0);
        chk("rst_mid_ready", req_ready, 1);
        chk("rst_mid_resp", resp_valid, 0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        run_req(1'b0, 2'b00, 1'b0, 64'd300, 64'd0, -1, 0, rd, mis, lat);
        chk("post_rst_lat", lat, 2);
        chk("post_rst_data", rd, 64'hFFFF_FFFF_FFFF_FF80);
        chk("rst_mid_mem", peek8(280), 64'hAAAA_AAAA_AA06_0708);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
